// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core: Moore sequencing FSM plus
// combinational ALU-control and immediate-format decoders.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECI    = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_reg;
  state_t     state_next;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: state_next = MEMWB;
      EXECR:   state_next = ALUWB;
      EXECI:   state_next = ALUWB;
      JAL:     state_next = ALUWB;
      default: state_next = FETCH;
    endcase
  end

  // Moore control word; reset overrides with FETCH datapath selects and no enables.
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    RegWrite  = 1'b0;
    case (state_reg)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b10;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      alu_op    = 2'b00;
    end
  end

  assign PCWrite = pc_update | (branch & Zero);

  // op[5] separates R-type from I-type, so I-type funct7 bits never select subtract.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign State = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction state traces and
// control words compared against a table-driven instruction-level model.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int n_cmp = 0;
  int n_fail = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite}
  wire [15:0] cw = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ALUControl, ImmSrc, RegWrite};

  int         obs_st[16];
  logic [15:0] obs_cw[16];
  int         obs_n;
  int         exp_q[$];

  // Expected control word for a given state, from the per-state control table.
  function automatic logic [15:0] exp_cw(int s, logic [6:0] o, logic [2:0] f3,
                                         logic f7, logic z, logic rst);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw} = 5'b0;
    {rs, sa, sb, aop} = 8'b0;
    if (rst) begin
      rs = 2; sb = 2;
    end else begin
      case (s)
        0:  begin pcw = 1; irw = 1; sb = 2; rs = 2; end
        1:  begin sa = 1; sb = 1; end
        2:  begin sa = 2; sb = 1; end
        3:  adr = 1;
        4:  begin rs = 1; rw = 1; end
        5:  begin adr = 1; mw = 1; end
        6:  begin sa = 2; aop = 2; end
        7:  rw = 1;
        8:  begin sa = 2; sb = 1; aop = 2; end
        9:  begin sa = 1; sb = 2; pcw = 1; end
        10: begin sa = 2; aop = 1; pcw = z; end
        default: ;
      endcase
    end
    if (aop == 0) alu = 3'b000;
    else if (aop == 1) alu = 3'b001;
    else begin
      case (f3)
        3'b000: alu = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
        3'b010: alu = 3'b101;
        3'b110: alu = 3'b011;
        3'b111: alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    case (o)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw};
  endfunction

  // Instruction-level model: the state path each opcode walks.
  task automatic model_seq(input logic [6:0] o);
    exp_q = {};
    exp_q.push_back(0);
    exp_q.push_back(1);
    case (o)
      7'b0000011: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
      7'b0100011: begin exp_q.push_back(2); exp_q.push_back(5); end
      7'b0110011: begin exp_q.push_back(6); exp_q.push_back(7); end
      7'b0010011: begin exp_q.push_back(8); exp_q.push_back(7); end
      7'b1101111: begin exp_q.push_back(9); exp_q.push_back(7); end
      7'b1100011: exp_q.push_back(10);
      default: ;
    endcase
  endtask

  // Drives one instruction from FETCH until State returns to 0; records trace only.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z);
    obs_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      #1;
      obs_st[obs_n] = int'(State);
      obs_cw[obs_n] = cw;
      obs_n++;
      @(posedge clk);
      #1;
      if (State == 4'd0) break;
    end
  endtask

  task automatic test_reset();
    logic [15:0] rcw;
    bit hit;
    reset = 1'b1;
    op = 7'b0100011;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      rcw = exp_cw(0, op, funct3, funct7b5, Zero, 1'b1);
      n_cmp++;
      if (cw !== rcw) begin n_fail++; $display("FAIL reset_cw cycle %0d got %h want %h", c, cw, rcw); end
    end
    n_cmp++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", State); end
    @(posedge clk); #1; reset = 1'b0;
    hit = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (State == 4'd5) begin hit = 1; break; end
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL reach_memwrite got %0d want 5", State); end
    reset = 1'b1;
    #1;
    rcw = exp_cw(0, op, funct3, funct7b5, Zero, 1'b1);
    n_cmp++;
    if (cw !== rcw) begin n_fail++; $display("FAIL reset_in_memwrite got %h want %h", cw, rcw); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (State !== 4'd0 || cw !== rcw) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d got st=%0d cw=%h want st=0 cw=%h", c, State, cw, rcw);
      end
    end
    @(posedge clk); #1; reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_load();
    int exp_lw[5] = '{0, 1, 2, 3, 4};
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    n_cmp++;
    if (obs_n !== 5) begin n_fail++; $display("FAIL lw_cycles got %0d want 5", obs_n); end
    for (int i = 0; i < 5 && i < obs_n; i++) begin
      n_cmp++;
      if (obs_st[i] !== exp_lw[i]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d want %0d", i, obs_st[i], exp_lw[i]); end
      n_cmp++;
      if (obs_cw[i][0] !== (i == 4)) begin n_fail++; $display("FAIL lw_regwrite[%0d] got %b want %b", i, obs_cw[i][0], i == 4); end
    end
    n_cmp++;
    if (obs_cw[4][11:10] !== 2'b01) begin n_fail++; $display("FAIL lw_resultsrc got %b want 01", obs_cw[4][11:10]); end
    n_cmp++;
    if (obs_cw[3][14] !== 1'b1) begin n_fail++; $display("FAIL lw_adrsrc got %b want 1", obs_cw[3][14]); end
    $display("test_load lw cycles=%0d", obs_n);
  endtask

  task automatic test_alu_decode();
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    n_cmp++;
    if (obs_st[2] !== 6 || obs_cw[2][5:3] !== 3'b001) begin
      n_fail++; $display("FAIL r_sub got st=%0d alu=%b want st=6 alu=001", obs_st[2], obs_cw[2][5:3]);
    end
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    n_cmp++;
    if (obs_st[2] !== 8 || obs_cw[2][5:3] !== 3'b000) begin
      n_fail++; $display("FAIL i_add got st=%0d alu=%b want st=8 alu=000", obs_st[2], obs_cw[2][5:3]);
    end
    $display("test_alu_decode done");
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      run_instr(7'b1100011, 3'b000, 1'b0, z[0]);
      n_cmp++;
      if (obs_n !== 3 || obs_st[2] !== 10) begin
        n_fail++; $display("FAIL beq_path z=%0d got n=%0d st=%0d want n=3 st=10", z, obs_n, obs_st[2]);
      end
      n_cmp++;
      if (obs_cw[2][15] !== z[0]) begin
        n_fail++; $display("FAIL beq_pcwrite z=%0d got %b want %b", z, obs_cw[2][15], z[0]);
      end
    end
    $display("test_branch done");
  endtask

  task automatic test_jal_illegal();
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    n_cmp++;
    if (obs_n !== 4 || obs_st[2] !== 9 || obs_st[3] !== 7) begin
      n_fail++; $display("FAIL jal_path got n=%0d st2=%0d st3=%0d want 4/9/7", obs_n, obs_st[2], obs_st[3]);
    end
    n_cmp++;
    if (obs_cw[2][15] !== 1'b1 || obs_cw[3][0] !== 1'b1 || obs_cw[2][2:1] !== 2'b11) begin
      n_fail++; $display("FAIL jal_ctrl got pcw=%b rw=%b imm=%b want 1/1/11", obs_cw[2][15], obs_cw[3][0], obs_cw[2][2:1]);
    end
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    n_cmp++;
    if (obs_n !== 2 || obs_st[1] !== 1) begin
      n_fail++; $display("FAIL illegal_path got n=%0d want 2", obs_n);
    end
    $display("test_jal_illegal done");
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1101111, 7'b1100011};
    logic [6:0] o;
    logic [2:0] f3;
    logic f7, z;
    int bad;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 6) == 6) begin
        o = 7'($urandom);
        while (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1101111, 7'b1100011}) o = 7'($urandom);
      end else o = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom); f7 = 1'($urandom); z = 1'($urandom);
      run_instr(o, f3, f7, z);
      model_seq(o);
      bad = 0;
      n_cmp++;
      if (obs_n !== exp_q.size()) begin
        n_fail++; bad = 1;
        $display("FAIL rnd_cycles op=%b got %0d want %0d", o, obs_n, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_n; i++) begin
        n_cmp++;
        if (obs_st[i] !== exp_q[i] || obs_cw[i] !== exp_cw(exp_q[i], o, f3, f7, z, 1'b0)) begin
          n_fail++; bad = 1;
          $display("FAIL rnd_step op=%b f3=%b f7=%b z=%b i=%0d got st=%0d cw=%h want st=%0d cw=%h",
                   o, f3, f7, z, i, obs_st[i], obs_cw[i], exp_q[i],
                   exp_cw(exp_q[i], o, f3, f7, z, 1'b0));
        end
      end
      $display("instr %0d op=%b f3=%b f7=%b z=%b cycles=%0d %s", t, o, f3, f7, z, obs_n,
               bad ? "bad" : "ok");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_decode();
    test_branch();
    test_jal_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
